spi3w_target: RTL and testbench

Three-wire half-duplex SPI target: the responder end of the SoC's SPI master (CS, SCLK, bidirectional SDIO). It oversamples the SPI pins in the system clock domain, decodes a command byte, and performs byte-wide register writes or reads on a simple parallel register port, driving SDIO during read turnaround. It is used as a bench/loopback peer for the SoC SPI master and as a host-side configuration port for peripherals.

---
 rtl/spi3w_target.sv | 179 +++++++++++++++++
 tb/tb_spi3w_target.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi3w_target.sv
`default_nettype none
// ============================================================================
// spi3w_target: three-wire half-duplex SPI target with a byte register port.
// Optional burst mode: define SPI3W_TARGET_AUTOINC_EN.  Rev 1.0
// ============================================================================
module spi3w_target #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_cs_i,
    input  logic              spi_sclk_i,
    input  logic              spi_sdio_i,
    output logic              spi_sdio_o,
    output logic              spi_sdio_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              frame_err_o
);

`ifdef SPI3W_TARGET_AUTOINC_EN
    localparam bit c_autoinc = 1'b1;
`else
    localparam bit c_autoinc = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cs_sync;
    logic [2:0]  r_sclk_sync;
    logic [1:0]  r_sdio_sync;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic        r_load;
    logic        r_done;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_rise;
    logic        w_cs_fall;
    logic [7:0]  w_rx_byte;

    // Stage [1] is the synchronized level, stage [2] the previous one for edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cs_sync   <= 3'b111;
            r_sclk_sync <= 3'b000;
            r_sdio_sync <= 2'b00;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs_i};
            r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk_i};
            r_sdio_sync <= {r_sdio_sync[0], spi_sdio_i};
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_rx_byte   = {r_rx_shift[6:0], r_sdio_sync[1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_shift    <= 8'd0;
            r_tx_shift    <= 8'd0;
            r_load        <= 1'b0;
            r_done        <= 1'b0;
            spi_sdio_o    <= 1'b0;
            spi_sdio_oe_o <= 1'b0;
            reg_addr_o    <= '0;
            reg_wdata_o   <= 8'd0;
            reg_we_o      <= 1'b0;
            reg_re_o      <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            frame_err_o <= 1'b0;

            if (r_load) begin
                r_tx_shift <= reg_rdata_i;
                r_load     <= 1'b0;
            end

            // Write address advances the cycle after the strobe so the strobe
            // itself carries the address the byte was meant for.
            if (c_autoinc && reg_we_o) begin
                reg_addr_o <= reg_addr_o + ADDR_W'(1);
            end

            if (w_cs_rise) begin
                r_state       <= S_IDLE;
                r_bit_cnt     <= 3'd0;
                r_done        <= 1'b0;
                r_load        <= 1'b0;
                spi_sdio_oe_o <= 1'b0;
                spi_sdio_o    <= 1'b0;
                frame_err_o   <= (r_bit_cnt != 3'd0);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state    <= S_CMD;
                            r_bit_cnt  <= 3'd0;
                            r_rx_shift <= 8'd0;
                            r_done     <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_byte;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                reg_addr_o <= w_rx_byte[ADDR_W-1:0];
                                if (w_rx_byte[7]) begin
                                    r_state  <= S_RDATA;
                                    reg_re_o <= 1'b1;
                                    r_load   <= 1'b1;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_sclk_rise && !r_done) begin
                            r_rx_shift <= w_rx_byte;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                reg_wdata_o <= w_rx_byte;
                                reg_we_o    <= 1'b1;
                                r_done      <= ~c_autoinc;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_sclk_fall) begin
                            if (!r_done) begin
                                spi_sdio_oe_o <= 1'b1;
                                spi_sdio_o    <= r_tx_shift[7];
                                r_tx_shift    <= {r_tx_shift[6:0], 1'b0};
                            end else begin
                                spi_sdio_oe_o <= 1'b0;
                                spi_sdio_o    <= 1'b0;
                            end
                        end
                        if (w_sclk_rise && !r_done) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (c_autoinc) begin
                                    reg_addr_o <= reg_addr_o + ADDR_W'(1);
                                    reg_re_o   <= 1'b1;
                                    r_load     <= 1'b1;
                                end else begin
                                    r_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi3w_target.sv
`default_nettype none
// ============================================================================
// tb_spi3w_target: randomized frames against a register-level model of the
// SPI target. Rev 1.0
// ============================================================================
module tb_spi3w_target;

    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;
    localparam int HP     = 6;
`ifdef SPI3W_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cs = 1'b1;
    logic              sclk = 1'b0;
    logic              mst_sdo = 1'b0;
    logic              sdio_pin;
    logic              sdio_o;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic              we;
    logic              re;
    logic [7:0]        rdata = 8'd0;
    logic              ferr;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    assign sdio_pin = oe ? sdio_o : mst_sdo;

    spi3w_target #(.ADDR_W(ADDR_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi_cs_i      (cs),
        .spi_sclk_i    (sclk),
        .spi_sdio_i    (sdio_pin),
        .spi_sdio_o    (sdio_o),
        .spi_sdio_oe_o (oe),
        .reg_addr_o    (addr),
        .reg_wdata_o   (wdata),
        .reg_we_o      (we),
        .reg_re_o      (re),
        .reg_rdata_i   (rdata),
        .frame_err_o   (ferr)
    );

    // Peripheral register file plus event logs; only this process writes them.
    logic [7:0]        regfile [NREG];
    logic [ADDR_W-1:0] we_addr [64];
    logic [7:0]        we_dat  [64];
    logic [ADDR_W-1:0] re_addr [64];
    int  we_n = 0, re_n = 0, ferr_n = 0, oe_n = 0;
    bit  rf_init = 1'b0;

    always @(negedge clk) begin
        if (rst && !rf_init) begin
            for (int i = 0; i < NREG; i++) regfile[i] = 8'(i * 17 + 3);
            rf_init = 1'b1;
        end
        if (we) begin
            we_addr[we_n % 64] = addr;
            we_dat[we_n % 64]  = wdata;
            regfile[addr]      = wdata;
            we_n++;
        end
        if (re) begin
            re_addr[re_n % 64] = addr;
            rdata              = regfile[addr];
            re_n++;
        end
        if (ferr) ferr_n++;
        if (oe) oe_n++;
    end

    logic [7:0] mdl [NREG];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master side: data set while SCLK low, sampled at SCLK rise (mode 0).
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            mst_sdo = tx[7-i];
            repeat (HP) @(negedge clk);
            sclk = 1'b1;
            rx = {rx[6:0], sdio_pin};
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int ndata, input int partial,
                             input logic [7:0] wd [4]);
        int we0 = we_n, re0 = re_n, fe0 = ferr_n, oe0 = oe_n;
        int base, nb, nre, exp_err, a;
        logic [7:0] rx [4];
        logic [7:0] tmp;
        cs = 1'b0;
        repeat (HP) @(negedge clk);
        xfer(cmd, 8, tmp);
        for (int i = 0; i < ndata; i++) xfer(wd[i], 8, rx[i]);
        if (partial != 0) xfer(8'($urandom), partial, tmp);
        mst_sdo = 1'b0;
        repeat (HP) @(negedge clk);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        check("oe_release", 32'(oe), 32'd0);
        repeat (6) @(negedge clk);

        base    = int'(cmd) % NREG;
        nb      = AUTOINC ? ndata : ((ndata > 0) ? 1 : 0);
        exp_err = (partial != 0 && (AUTOINC || ndata == 0)) ? 1 : 0;
        if (!cmd[7]) begin
            check("we_count", 32'(we_n - we0), 32'(nb));
            for (int i = 0; i < nb; i++) begin
                a = (base + i) % NREG;
                check("we_addr", 32'(we_addr[(we0 + i) % 64]), 32'(a));
                check("we_data", 32'(we_dat[(we0 + i) % 64]), 32'(wd[i]));
                mdl[a] = wd[i];
            end
            check("re_in_write", 32'(re_n - re0), 32'd0);
            check("oe_in_write", 32'(oe_n - oe0), 32'd0);
        end else begin
            nre = AUTOINC ? ndata + 1 : 1;
            check("re_count", 32'(re_n - re0), 32'(nre));
            for (int i = 0; i < nre && i < 4; i++)
                check("re_addr", 32'(re_addr[(re0 + i) % 64]), 32'((base + i) % NREG));
            for (int i = 0; i < nb; i++)
                check("rd_data", 32'(rx[i]), 32'(mdl[(base + i) % NREG]));
            check("we_in_read", 32'(we_n - we0), 32'd0);
        end
        check("frame_err", 32'(ferr_n - fe0), 32'(exp_err));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] wd [4];
        logic [7:0] tmp;
        int we0, re0, fe0;
        for (int i = 0; i < NREG; i++) mdl[i] = 8'(i * 17 + 3);

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({oe, sdio_o, we, re, ferr, addr, wdata}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        wd = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(8'h03, 1, 0, wd);
        wd = '{8'h3C, 8'h00, 8'h00, 8'h00};
        run_frame(8'h05, 1, 0, wd);
        run_frame(8'h85, 1, 0, wd);
        run_frame(8'h02, 0, 5, wd);
        wd = '{8'h5A, 8'h00, 8'h00, 8'h00};
        run_frame(8'h02, 1, 0, wd);
        wd = '{8'h11, 8'h22, 8'h00, 8'h00};
        run_frame(8'h0F, 2, 0, wd);
        run_frame(8'h8F, 2, 0, wd);
        wd = '{8'h77, 8'h00, 8'h00, 8'h00};
        run_frame(8'h7A, 1, 0, wd);

        // Reset in the middle of a read data byte.
        cs = 1'b0;
        repeat (HP) @(negedge clk);
        xfer(8'h85, 8, tmp);
        xfer(8'h00, 3, tmp);
        we0 = we_n; re0 = re_n; fe0 = ferr_n;
        rst = 1'b1;
        @(negedge clk);
        check("reset_midframe", 32'({oe, sdio_o, we, re, ferr, addr, wdata}), 32'd0);
        rst = 1'b0;
        cs  = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_no_strobe", 32'((we_n - we0) + (re_n - re0) + (ferr_n - fe0)), 32'd0);
        run_frame(8'h85, 1, 0, wd);

        for (int f = 0; f < 24; f++) begin
            int nd, pb;
            for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
            nd = $urandom_range(0, 3);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_frame(8'($urandom), nd, pb, wd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
